// File: rtl/phase_sequencer.sv
// phase_sequencer
//
// Run controller for the arbitrage engine. Launches NUM_PHASES compute engines
// one after another over a start/done handshake and routes the active engine's
// shared-memory request bus onto the single memory port. Each phase is guarded
// by a watchdog; a run can be aborted at any time. It can also re-run
// continuously. Completed runs are counted.
//
// Ports
//   clk, reset      clock, synchronous active-high reset
//   start           begin a run (accepted in IDLE, DONE, FAULT)
//   abort           return to IDLE from any state
//   continuous      re-launch phase 0 automatically after DONE
//   src_in          source vertex, latched when a start is accepted
//   timeout_limit   max WAIT cycles per phase, 0 disables the watchdog
//   phase_start     one-cycle launch pulse per engine
//   phase_done      engine completion pulses
//   eng_addr/eng_data/eng_we  packed engine memory request buses
//   mem_addr/mem_data/mem_we  muxed memory request (combinational)
//   src_out         latched source vertex
//   active_phase    index of the current phase
//   busy/done/error high in LAUNCH-WAIT / DONE / FAULT
//   run_count       completed runs, wraps at 0xFFFF
module phase_sequencer #(
   parameter int NUM_PHASES = 2,
   parameter int ADDR_W     = 8,
   parameter int DATA_W     = 32,
   parameter int TMO_W      = 16
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         start,
   input  logic                         abort,
   input  logic                         continuous,
   input  logic [ADDR_W-1:0]            src_in,
   input  logic [TMO_W-1:0]             timeout_limit,
   output logic [NUM_PHASES-1:0]        phase_start,
   input  logic [NUM_PHASES-1:0]        phase_done,
   input  logic [NUM_PHASES*ADDR_W-1:0] eng_addr,
   input  logic [NUM_PHASES*DATA_W-1:0] eng_data,
   input  logic [NUM_PHASES-1:0]        eng_we,
   output logic [ADDR_W-1:0]            mem_addr,
   output logic [DATA_W-1:0]            mem_data,
   output logic                         mem_we,
   output logic [ADDR_W-1:0]            src_out,
   output logic [2:0]                   active_phase,
   output logic                         busy,
   output logic                         done,
   output logic                         error,
   output logic [15:0]                  run_count
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LAUNCH,
      ST_WAIT,
      ST_DONE,
      ST_FAULT
   } state_t;

   localparam logic [2:0] LAST_PHASE = 3'(NUM_PHASES - 1);

   state_t                  state_q, state_d;
   logic [2:0]              phase_q, phase_d;
   logic [NUM_PHASES-1:0]   phase_start_q, phase_start_d;
   logic [15:0]             run_count_q, run_count_d;
   logic [ADDR_W-1:0]       src_q, src_d;
   logic [TMO_W-1:0]        wdog_q, wdog_d;
   logic                    busy_q, busy_d;
   logic                    done_q, done_d;
   logic                    error_q, error_d;

   logic                    done_sel;
   logic [ADDR_W-1:0]       sel_addr;
   logic [DATA_W-1:0]       sel_data;
   logic                    sel_we;

   // Select the active engine's done bit and memory request. A compare loop is
   // used instead of direct indexing so a 3-bit phase index never reaches
   // past NUM_PHASES.
   always_comb begin
      done_sel = 1'b0;
      sel_addr = '0;
      sel_data = '0;
      sel_we   = 1'b0;
      for (int i = 0; i < NUM_PHASES; i++) begin
         if (phase_q == 3'(i)) begin
            done_sel = phase_done[i];
            sel_addr = eng_addr[i*ADDR_W +: ADDR_W];
            sel_data = eng_data[i*DATA_W +: DATA_W];
            sel_we   = eng_we[i];
         end
      end
   end

   // Next-state and registered-output logic
   always_comb begin
      state_d       = state_q;
      phase_d       = phase_q;
      run_count_d   = run_count_q;
      src_d         = src_q;
      wdog_d        = wdog_q;
      phase_start_d = '0;

      case (state_q)
         ST_IDLE, ST_FAULT: begin
            // FAULT keeps the failing phase index visible until restarted
            if (start) begin
               src_d   = src_in;
               phase_d = 3'd0;
               state_d = ST_LAUNCH;
            end
         end
         ST_LAUNCH: begin
            wdog_d  = '0;
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            // Completion takes precedence over a watchdog expiry in the same cycle
            if (done_sel) begin
               if (phase_q == LAST_PHASE) begin
                  run_count_d = run_count_q + 16'd1;
                  state_d     = ST_DONE;
               end else begin
                  phase_d = phase_q + 3'd1;
                  state_d = ST_LAUNCH;
               end
            end else begin
               wdog_d = wdog_q + TMO_W'(1);
               // Comparing against limit-1 faults after exactly limit WAIT cycles
               if ((timeout_limit != '0) && (wdog_q == timeout_limit - TMO_W'(1))) begin
                  state_d = ST_FAULT;
               end
            end
         end
         ST_DONE: begin
            if (start) begin
               src_d   = src_in;
               phase_d = 3'd0;
               state_d = ST_LAUNCH;
            end else if (continuous) begin
               phase_d = 3'd0;
               state_d = ST_LAUNCH;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Abort overrides everything that happened above; counters and the
      // latched source are kept, only the sequencing position is dropped.
      if (abort) begin
         state_d     = ST_IDLE;
         phase_d     = 3'd0;
         run_count_d = run_count_q;
         src_d       = src_q;
         wdog_d      = '0;
      end

      // Outputs are decoded from the next state so they appear registered
      if (state_d == ST_LAUNCH) begin
         for (int i = 0; i < NUM_PHASES; i++) begin
            phase_start_d[i] = (phase_d == 3'(i));
         end
      end
      busy_d  = (state_d == ST_LAUNCH) || (state_d == ST_WAIT);
      done_d  = (state_d == ST_DONE);
      error_d = (state_d == ST_FAULT);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= ST_IDLE;
         phase_q       <= 3'd0;
         phase_start_q <= '0;
         run_count_q   <= 16'd0;
         src_q         <= '0;
         wdog_q        <= '0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         error_q       <= 1'b0;
      end else begin
         state_q       <= state_d;
         phase_q       <= phase_d;
         phase_start_q <= phase_start_d;
         run_count_q   <= run_count_d;
         src_q         <= src_d;
         wdog_q        <= wdog_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
         error_q       <= error_d;
      end
   end

   // Memory port is combinational from registered state so the engine sees
   // no extra latency to memory; outside a run the port is held quiet.
   always_comb begin
      mem_addr = '0;
      mem_data = '0;
      mem_we   = 1'b0;
      if ((state_q == ST_LAUNCH) || (state_q == ST_WAIT)) begin
         mem_addr = sel_addr;
         mem_data = sel_data;
         mem_we   = sel_we;
      end
   end

   assign phase_start  = phase_start_q;
   assign src_out      = src_q;
   assign active_phase = phase_q;
   assign busy         = busy_q;
   assign done         = done_q;
   assign error        = error_q;
   assign run_count    = run_count_q;

endmodule

// File: tb/tb_phase_sequencer.sv
// Testbench for phase_sequencer: directed stimulus, expected launch/done/fault
// events queued by the stimulus and compared by an independent monitor.
module tb_phase_sequencer;

   localparam int NP = 2;
   localparam int AW = 8;
   localparam int DW = 32;
   localparam int TW = 16;

   logic             clk = 1'b0;
   logic             reset;
   logic             start;
   logic             abort;
   logic             continuous;
   logic [AW-1:0]    src_in;
   logic [TW-1:0]    timeout_limit;
   logic [NP-1:0]    phase_start;
   logic [NP-1:0]    phase_done;
   logic [NP*AW-1:0] eng_addr;
   logic [NP*DW-1:0] eng_data;
   logic [NP-1:0]    eng_we;
   logic [AW-1:0]    mem_addr;
   logic [DW-1:0]    mem_data;
   logic             mem_we;
   logic [AW-1:0]    src_out;
   logic [2:0]       active_phase;
   logic             busy;
   logic             done;
   logic             error;
   logic [15:0]      run_count;

   phase_sequencer #(
      .NUM_PHASES(NP), .ADDR_W(AW), .DATA_W(DW), .TMO_W(TW)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .abort(abort),
      .continuous(continuous), .src_in(src_in), .timeout_limit(timeout_limit),
      .phase_start(phase_start), .phase_done(phase_done),
      .eng_addr(eng_addr), .eng_data(eng_data), .eng_we(eng_we),
      .mem_addr(mem_addr), .mem_data(mem_data), .mem_we(mem_we),
      .src_out(src_out), .active_phase(active_phase), .busy(busy),
      .done(done), .error(error), .run_count(run_count)
   );

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct packed {
      logic [31:0]   cyc;
      logic [NP-1:0] ps;
      logic          dn;
      logic          er;
      logic [2:0]    ap;
      logic [15:0]   rc;
      logic [AW-1:0] src;
   } ev_t;

   ev_t exp_q[$];

   int  dir_checks = 0, dir_pass = 0;
   int  mon_checks = 0, mon_pass = 0;
   bit  mon_en = 1'b0;
   logic done_prev = 1'b0, error_prev = 1'b0;

   // Monitor: an event is any launch pulse or a rising done/error
   always @(negedge clk) begin : monitor
      ev_t a, e;
      if (mon_en) begin
         if ((phase_start != '0) || (done && !done_prev) || (error && !error_prev)) begin
            a = {cyc, phase_start, done, error, active_phase, run_count, src_out};
            mon_checks <= mon_checks + 1;
            if (exp_q.size() == 0) begin
               $display("FAIL event: unexpected cyc=%0d ps=%b done=%b err=%b ap=%0d rc=%0h src=%0h, required none",
                        a.cyc, a.ps, a.dn, a.er, a.ap, a.rc, a.src);
            end else begin
               e = exp_q.pop_front();
               if (a === e) mon_pass <= mon_pass + 1;
               else $display("FAIL event: got cyc=%0d ps=%b done=%b err=%b ap=%0d rc=%0h src=%0h, required cyc=%0d ps=%b done=%b err=%b ap=%0d rc=%0h src=%0h",
                             a.cyc, a.ps, a.dn, a.er, a.ap, a.rc, a.src,
                             e.cyc, e.ps, e.dn, e.er, e.ap, e.rc, e.src);
            end
         end
         done_prev  <= done;
         error_prev <= error;
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      dir_checks++;
      if (act === req) dir_pass++;
      else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
   endtask

   task automatic push(input int unsigned c, input logic [NP-1:0] ps, input logic dn,
                       input logic er, input logic [2:0] ap, input logic [15:0] rc,
                       input logic [AW-1:0] s);
      ev_t e;
      e = {c, ps, dn, er, ap, rc, s};
      exp_q.push_back(e);
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Called at the negedge of a LAUNCH cycle; engine idx completes on its k-th WAIT cycle
   task automatic pdone(input int idx, input int k);
      step(k);
      phase_done[idx] = 1'b1;
      step(1);
      phase_done = '0;
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, required completion");
      $fatal(1, "time limit");
   end

   initial begin
      int unsigned t;
      reset         = 1'b1;
      start         = 1'b0;
      abort         = 1'b0;
      continuous    = 1'b0;
      src_in        = '0;
      timeout_limit = '0;
      phase_done    = '0;
      eng_addr      = {8'h2A, 8'h11};
      eng_data      = {32'h1234_5678, 32'hAAAA_0000};
      eng_we        = 2'b10;
      step(3);

      check("rst_phase_start", phase_start, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_error", error, 0);
      check("rst_run_count", run_count, 0);
      check("rst_src_out", src_out, 0);
      check("rst_active_phase", active_phase, 0);
      check("rst_mem_we", mem_we, 0);
      check("rst_mem_addr", mem_addr, 0);
      check("rst_mem_data", mem_data, 0);
      reset  = 1'b0;
      mon_en = 1'b1;

      // Basic run: phase 0 done after 3 WAIT cycles, phase 1 after 7
      t = cyc;
      push(t + 1,  2'b01, 0, 0, 3'd0, 16'd0, 8'd5);
      push(t + 5,  2'b10, 0, 0, 3'd1, 16'd0, 8'd5);
      push(t + 13, 2'b00, 1, 0, 3'd1, 16'd1, 8'd5);
      start  = 1'b1;
      src_in = 8'd5;
      step(1);                      // LAUNCH phase 0
      start      = 1'b0;
      src_in     = 8'd9;
      phase_done = 2'b01;           // done during LAUNCH: ignored
      check("launch_busy", busy, 1);
      step(1);                      // WAIT 1
      phase_done = 2'b10;           // stray done from inactive engine
      check("p0_mem_addr", mem_addr, 8'h11);
      check("p0_mem_we", mem_we, 0);
      check("p0_mem_data", mem_data, 32'hAAAA_0000);
      step(1);                      // WAIT 2
      phase_done = 2'b00;
      step(1);                      // WAIT 3
      phase_done = 2'b01;
      step(1);                      // LAUNCH phase 1
      phase_done = 2'b10;           // done during LAUNCH: ignored
      step(1);                      // WAIT 1
      phase_done = 2'b00;
      check("p1_mem_addr", mem_addr, 8'h2A);
      check("p1_mem_we", mem_we, 1);
      check("p1_mem_data", mem_data, 32'h1234_5678);
      check("p1_active_phase", active_phase, 1);
      step(6);                      // WAIT 7
      phase_done = 2'b10;
      step(1);                      // DONE
      phase_done = 2'b00;
      check("done_mem_we", mem_we, 0);
      check("done_mem_addr", mem_addr, 0);
      check("done_mem_data", mem_data, 0);
      check("done_busy", busy, 0);
      step(3);
      check("done_hold", done, 1);
      check("run1_count", run_count, 1);
      check("run1_src_out", src_out, 5);

      // Watchdog: limit 4, engine 0 silent
      timeout_limit = 16'd4;
      t = cyc;
      push(t + 1, 2'b01, 0, 0, 3'd0, 16'd1, 8'd7);
      push(t + 6, 2'b00, 0, 1, 3'd0, 16'd1, 8'd7);
      start  = 1'b1;
      src_in = 8'd7;
      step(1);
      start = 1'b0;
      step(4);                      // 4th WAIT cycle
      check("wdog_not_yet", error, 0);
      step(1);                      // FAULT
      check("fault_busy", busy, 0);
      check("fault_mem_we", mem_we, 0);
      check("fault_phase", active_phase, 0);
      step(2);
      check("fault_hold", error, 1);

      // Restart from FAULT; phase 1 completes on the last allowed WAIT cycle
      t = cyc;
      push(t + 1, 2'b01, 0, 0, 3'd0, 16'd1, 8'd7);
      push(t + 4, 2'b10, 0, 0, 3'd1, 16'd1, 8'd7);
      push(t + 9, 2'b00, 1, 0, 3'd1, 16'd2, 8'd7);
      start = 1'b1;
      step(1);
      start = 1'b0;
      check("restart_error_clr", error, 0);
      pdone(0, 2);
      pdone(1, 4);
      check("edge_run_done", done, 1);

      // Continuous mode: three back-to-back minimum-length runs
      timeout_limit = 16'd0;
      t = cyc;
      push(t + 1, 2'b01, 0, 0, 3'd0, 16'd2, 8'd7);
      continuous = 1'b1;
      step(1);
      for (int r = 0; r < 3; r++) begin
         int unsigned b;
         b = cyc;
         push(b + 2, 2'b10, 0, 0, 3'd1, 16'(2 + r), 8'd7);
         push(b + 4, 2'b00, 1, 0, 3'd1, 16'(3 + r), 8'd7);
         if (r < 2) push(b + 5, 2'b01, 0, 0, 3'd0, 16'(3 + r), 8'd7);
         pdone(0, 1);
         pdone(1, 1);
         if (r == 2) continuous = 1'b0;
         else begin
            step(1);
            check("cont_done_pulse", done, 0);
         end
      end
      step(2);
      check("cont_final_done", done, 1);
      check("cont_run_count", run_count, 16'd5);

      // run_count wrap from 0xFFFF
      force dut.run_count_q = 16'hFFFF;
      step(2);
      release dut.run_count_q;
      step(1);
      t = cyc;
      push(t + 1, 2'b01, 0, 0, 3'd0, 16'hFFFF, 8'd3);
      push(t + 3, 2'b10, 0, 0, 3'd1, 16'hFFFF, 8'd3);
      push(t + 5, 2'b00, 1, 0, 3'd1, 16'h0000, 8'd3);
      start  = 1'b1;
      src_in = 8'd3;
      step(1);
      start = 1'b0;
      pdone(0, 1);
      pdone(1, 1);
      check("wrap_run_count", run_count, 0);

      // Abort concurrent with phase_done[0]
      t = cyc;
      push(t + 1, 2'b01, 0, 0, 3'd0, 16'd0, 8'd4);
      start  = 1'b1;
      src_in = 8'd4;
      step(1);
      start = 1'b0;
      step(1);                      // WAIT
      phase_done = 2'b01;
      abort      = 1'b1;
      step(1);
      phase_done = 2'b00;
      abort      = 1'b0;
      check("abort_busy", busy, 0);
      check("abort_done", done, 0);
      check("abort_phase", active_phase, 0);
      check("abort_mem_we", mem_we, 0);
      check("abort_run_count", run_count, 0);
      check("abort_src_out", src_out, 4);
      step(4);
      check("abort_idle_busy", busy, 0);

      for (int i = 0; i < 20 && exp_q.size() != 0; i++) step(1);
      check("pending_events", exp_q.size(), 0);
      step(1);

      $display("%0d/%0d checks passed", dir_pass + mon_pass, dir_checks + mon_checks);
      $finish;
   end

endmodule
